// File: rtl/add_sub_pkg.sv
// Shared definitions for the pipelined adder/subtractor: chunk sizing, the
// configuration legality rule and the per-stage flag record.
package add_sub_pkg;

  function automatic int chunk_w(input int n, input int stages);
    return n / stages;
  endfunction

  // Legal configurations split N into 1..N equal chunks.
  function automatic bit cfg_ok(input int n, input int stages);
    return (stages >= 1) && (stages <= n) && ((n % stages) == 0);
  endfunction

  typedef struct packed {
    logic carry;  // carry into the next chunk; carry out of bit N-1 at the last stage
    logic zero;   // AND of the per-chunk zero bits completed so far
    logic c_msb;  // carry into the top bit of this stage's chunk
  } stage_flags_t;

endpackage

// File: rtl/add_chunk.sv
// Combinational W-bit ripple-carry slice built from full adders; also exposes
// the carry into its top bit for signed-overflow detection.
module add_chunk
  import add_sub_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout,
  output logic         c_msb
);

  logic [W:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < W; i++) begin
      s[i]     = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout  = c[W];
  assign c_msb = c[W - 1];

endmodule

// File: rtl/add_sub_pipe.sv
// Pipelined N-bit adder/subtractor: one W-bit chunk per stage with the
// inter-chunk carry registered, valid/ready on both sides.
module add_sub_pipe
  import add_sub_pkg::*;
#(
  parameter int N      = 32,
  parameter int STAGES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] s,
  output logic         cout,
  output logic         ovf,
  output logic         zero
);

  localparam int W = chunk_w(N, STAGES);

  if (!cfg_ok(N, STAGES)) begin : g_bad_cfg
    $error("add_sub_pipe: STAGES must lie in 1..N and divide N exactly");
  end

  // Handshake: a beat moves on either side only in a cycle where valid and
  // ready are both high; valid never waits on ready, and a stage refills
  // whenever it is empty or its successor is taking its beat.
  logic [STAGES:0]   rdy;
  logic [STAGES-1:0] v_q, v_d, src_v, src_z;

  logic [N-1:0]  a_q [STAGES];
  logic [N-1:0]  a_d [STAGES];
  logic [N-1:0]  bp_q [STAGES];
  logic [N-1:0]  bp_d [STAGES];
  logic [N-1:0]  res_q [STAGES];
  logic [N-1:0]  res_d [STAGES];
  stage_flags_t  fl_q [STAGES];
  stage_flags_t  fl_d [STAGES];

  logic [N-1:0]  src_a [STAGES];
  logic [N-1:0]  src_b [STAGES];
  logic [N-1:0]  src_res [STAGES];

  logic [STAGES-1:0][W-1:0] ch_a, ch_b, ch_s;
  logic [STAGES-1:0]        ch_c, ch_co, ch_cm;

  always_comb begin : ready_chain
    logic r;
    r           = out_ready;
    rdy         = '0;
    rdy[STAGES] = r;
    for (int k = STAGES - 1; k >= 0; k--) begin
      r      = !v_q[k] || r;
      rdy[k] = r;
    end
  end

  // Stage 0 takes the ports; the operand is complemented once on entry so
  // later stages only ever add.
  always_comb begin : stage_inputs
    src_a[0]   = a;
    src_b[0]   = sub ? ~b : b;
    src_res[0] = '0;
    src_z[0]   = 1'b1;
    src_v[0]   = in_valid;
    ch_c       = '0;
    ch_c[0]    = sub | cin;
    for (int k = 1; k < STAGES; k++) begin
      src_a[k]   = a_q[k - 1];
      src_b[k]   = bp_q[k - 1];
      src_res[k] = res_q[k - 1];
      src_z[k]   = fl_q[k - 1].zero;
      src_v[k]   = v_q[k - 1];
      ch_c[k]    = fl_q[k - 1].carry;
    end
    for (int k = 0; k < STAGES; k++) begin
      ch_a[k] = src_a[k][k*W +: W];
      ch_b[k] = src_b[k][k*W +: W];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_chunk
    add_chunk #(.W(W)) u_chunk (
      .a     (ch_a[k]),
      .b     (ch_b[k]),
      .cin   (ch_c[k]),
      .s     (ch_s[k]),
      .cout  (ch_co[k]),
      .c_msb (ch_cm[k])
    );
  end

  always_comb begin : next_state
    v_d = v_q;
    for (int k = 0; k < STAGES; k++) begin
      a_d[k]   = a_q[k];
      bp_d[k]  = bp_q[k];
      res_d[k] = res_q[k];
      fl_d[k]  = fl_q[k];
      if (rdy[k]) begin
        v_d[k]                = src_v[k];
        a_d[k]                = src_a[k];
        bp_d[k]               = src_b[k];
        res_d[k]              = src_res[k];
        res_d[k][k*W +: W]    = ch_s[k];
        fl_d[k].carry         = ch_co[k];
        fl_d[k].zero          = src_z[k] & (ch_s[k] == '0);
        fl_d[k].c_msb         = ch_cm[k];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= '0;
        bp_q[k]  <= '0;
        res_q[k] <= '0;
        fl_q[k]  <= '0;
      end
    end else begin
      v_q <= v_d;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= a_d[k];
        bp_q[k]  <= bp_d[k];
        res_q[k] <= res_d[k];
        fl_q[k]  <= fl_d[k];
      end
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = v_q[STAGES - 1];
  assign s         = res_q[STAGES - 1];
  assign cout      = fl_q[STAGES - 1].carry;
  assign ovf       = fl_q[STAGES - 1].carry ^ fl_q[STAGES - 1].c_msb;
  assign zero      = fl_q[STAGES - 1].zero;

endmodule
